// File: rtl/mem_spi_arbiter.sv
// mem_spi_arbiter: shares the board-to-board SPI master between two byte
// requesters, owns the go/busy handshake and recovers a hung transfer.
module mem_spi_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter bit          FIXED_PRIO     = 1'b0,
  parameter logic [7:0]  ERR_BYTE       = 8'hFF
) (
  input  logic       SYSCLK,
  input  logic       resetb,
  input  logic       req0,
  input  logic [7:0] wdata0,
  output logic [7:0] rdata0,
  output logic       done0,
  input  logic       req1,
  input  logic [7:0] wdata1,
  output logic [7:0] rdata1,
  output logic       done1,
  output logic       spi_go,
  output logic [7:0] spi_datai,
  input  logic       spi_busy,
  input  logic [7:0] spi_datao,
  output logic       spi_resetb,
  output logic       owner,
  output logic       active,
  output logic       err_timeout,
  input  logic       err_clear
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_XFER,
    S_DONE,
    S_RECOVER,
    S_ABORT
  } state_t;

  state_t        state;
  logic [CW-1:0] tcnt;
  logic          last_grant;
  logic          abort_ph;
  logic          pick1;
  logic          tmo;

  // Requester 1 wins when alone, or on a round-robin tie after requester 0
  assign pick1 = req1 & (~req0 | (~FIXED_PRIO & ~last_grant));
  assign tmo   = (tcnt == TLAST);

  always_ff @(posedge SYSCLK or negedge resetb) begin
    if (!resetb) begin
      state       <= S_IDLE;
      tcnt        <= '0;
      last_grant  <= 1'b1;
      abort_ph    <= 1'b0;
      spi_go      <= 1'b0;
      spi_datai   <= 8'h00;
      spi_resetb  <= 1'b0;
      rdata0      <= 8'h00;
      rdata1      <= 8'h00;
      done0       <= 1'b0;
      done1       <= 1'b0;
      owner       <= 1'b0;
      active      <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      spi_resetb <= 1'b1;
      done0      <= 1'b0;
      done1      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req0 | req1) begin
            owner     <= pick1;
            spi_datai <= pick1 ? wdata1 : wdata0;
            tcnt      <= '0;
            spi_go    <= 1'b1;
            active    <= 1'b1;
            state     <= S_LAUNCH;
          end
        end
        S_LAUNCH, S_XFER: begin
          tcnt <= tcnt + CW'(1);
          if (tmo) begin
            spi_go      <= 1'b0;
            spi_resetb  <= 1'b0;
            err_timeout <= 1'b1;
            if (owner) rdata1 <= ERR_BYTE;
            else       rdata0 <= ERR_BYTE;
            abort_ph    <= 1'b0;
            state       <= S_ABORT;
          end else if (state == S_LAUNCH) begin
            if (spi_busy) begin
              spi_go <= 1'b0;
              state  <= S_XFER;
            end
          end else if (!spi_busy) begin
            if (owner) begin
              rdata1 <= spi_datao;
              done1  <= 1'b1;
            end else begin
              rdata0 <= spi_datao;
              done0  <= 1'b1;
            end
            state <= S_DONE;
          end
        end
        // Hold the master in reset for two cycles, then finish as DONE
        S_ABORT: begin
          if (!abort_ph) begin
            abort_ph   <= 1'b1;
            spi_resetb <= 1'b0;
          end else begin
            if (owner) done1 <= 1'b1;
            else       done0 <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          last_grant <= owner;
          state      <= S_RECOVER;
        end
        S_RECOVER: begin
          active <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          active <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
      if (err_clear) err_timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_spi_arbiter.sv
// tb_mem_spi_arbiter: directed vectors for the SPI arbiter, plus
// sequences for timeout, reset abort and request timing.
module tb_mem_spi_arbiter;

  logic SYSCLK = 1'b0;
  logic resetb = 1'b0;
  always #5 SYSCLK = ~SYSCLK;

  logic       a_req0 = 0, a_req1 = 0, a_clr = 0;
  logic [7:0] a_w0 = 0, a_w1 = 0;
  logic [7:0] a_rd0, a_rd1, a_di;
  logic       a_d0, a_d1, a_go, a_srb, a_own, a_act, a_err;

  logic       b_req0 = 0, b_req1 = 0, b_clr = 0;
  logic [7:0] b_w0 = 0, b_w1 = 0;
  logic [7:0] b_rd0, b_rd1, b_di;
  logic       b_d0, b_d1, b_go, b_srb, b_own, b_act, b_err;

  logic [1:0] busy = 2'b00;
  logic [7:0] sdo [2] = '{8'h00, 8'h00};
  logic [1:0] never = 2'b00;
  logic [7:0] mval [2] = '{8'h00, 8'h00};
  int         mlen [2] = '{16, 4};
  int         mst  [2] = '{0, 0};
  int         mcnt [2] = '{0, 0};
  logic [1:0] go_v, srb_v;

  assign go_v  = {b_go, a_go};
  assign srb_v = {b_srb, a_srb};

  mem_spi_arbiter u_a (
    .SYSCLK(SYSCLK), .resetb(resetb),
    .req0(a_req0), .wdata0(a_w0), .rdata0(a_rd0), .done0(a_d0),
    .req1(a_req1), .wdata1(a_w1), .rdata1(a_rd1), .done1(a_d1),
    .spi_go(a_go), .spi_datai(a_di), .spi_busy(busy[0]),
    .spi_datao(sdo[0]), .spi_resetb(a_srb), .owner(a_own),
    .active(a_act), .err_timeout(a_err), .err_clear(a_clr)
  );

  mem_spi_arbiter #(.TIMEOUT_CYCLES(16), .FIXED_PRIO(1'b1)) u_b (
    .SYSCLK(SYSCLK), .resetb(resetb),
    .req0(b_req0), .wdata0(b_w0), .rdata0(b_rd0), .done0(b_d0),
    .req1(b_req1), .wdata1(b_w1), .rdata1(b_rd1), .done1(b_d1),
    .spi_go(b_go), .spi_datai(b_di), .spi_busy(busy[1]),
    .spi_datao(sdo[1]), .spi_resetb(b_srb), .owner(b_own),
    .active(b_act), .err_timeout(b_err), .err_clear(b_clr)
  );

  // SPI master model: busy 2 cycles after go, for mlen cycles
  always @(negedge SYSCLK) begin
    for (int i = 0; i < 2; i++) begin
      if (!srb_v[i]) begin
        mst[i] = 0; mcnt[i] = 0; busy[i] = 1'b0;
      end else begin
        case (mst[i])
          0: if (go_v[i] && !never[i]) begin mst[i] = 1; mcnt[i] = 1; end
          1: if (mcnt[i] == 2) begin
               busy[i] = 1'b1; mst[i] = 2; mcnt[i] = 1;
             end else mcnt[i]++;
          2: if (mcnt[i] == mlen[i]) begin
               sdo[i] = mval[i]; busy[i] = 1'b0; mst[i] = 0;
             end else mcnt[i]++;
          default: mst[i] = 0;
        endcase
      end
    end
  end

  int   n_a0 = 0, n_a1 = 0, n_b0 = 0, n_b1 = 0, go_viol = 0;
  logic busy_q = 1'b0;
  always @(posedge SYSCLK) busy_q <= busy[0];
  always @(negedge SYSCLK) begin
    if (a_d0) n_a0++;
    if (a_d1) n_a1++;
    if (b_d0) n_b0++;
    if (b_d1) n_b1++;
    if (busy_q && a_go) go_viol++;
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_done(input int inst, input string nm);
    bit ok = 0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge SYSCLK);
      ok = (inst == 0) ? (a_d0 | a_d1) : (b_d0 | b_d1);
    end
    chk(nm, ok, 1);
  endtask

  task automatic wait_busy(input string nm);
    bit ok = 0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge SYSCLK);
      ok = busy[0];
    end
    chk(nm, ok, 1);
  endtask

  typedef struct {
    logic       r0, r1;
    logic [7:0] w0, w1, sdo;
    logic       eo;
    logic [7:0] edi, erd;
  } vec_t;

  vec_t       tv [6];
  logic [7:0] exp_rd [2];
  int         e0, e1;

  initial begin
    tv[0] = '{1'b1, 1'b0, 8'hFC, 8'h00, 8'hA5, 1'b0, 8'hFC, 8'hA5};
    tv[1] = '{1'b0, 1'b1, 8'h00, 8'h5A, 8'h3C, 1'b1, 8'h5A, 8'h3C};
    tv[2] = '{1'b1, 1'b1, 8'h11, 8'h22, 8'h81, 1'b0, 8'h11, 8'h81};
    tv[3] = '{1'b1, 1'b1, 8'h11, 8'h22, 8'h82, 1'b1, 8'h22, 8'h82};
    tv[4] = '{1'b1, 1'b1, 8'h11, 8'h22, 8'h83, 1'b0, 8'h11, 8'h83};
    tv[5] = '{1'b1, 1'b1, 8'h11, 8'h22, 8'h84, 1'b1, 8'h22, 8'h84};
    exp_rd = '{8'h00, 8'h00};
    e0 = 0; e1 = 0;

    repeat (3) @(negedge SYSCLK);
    chk("rst_go", a_go, 0);
    chk("rst_srb", a_srb, 0);
    chk("rst_act", a_act, 0);
    chk("rst_own", a_own, 0);
    chk("rst_rd0", a_rd0, 0);
    chk("rst_done", {a_d0, a_d1}, 0);
    chk("rst_err", a_err, 0);
    resetb = 1'b1;
    @(negedge SYSCLK);
    chk("srb_after_rst", a_srb, 1);

    for (int i = 0; i < 6; i++) begin
      a_req0 = tv[i].r0; a_req1 = tv[i].r1;
      a_w0 = tv[i].w0; a_w1 = tv[i].w1;
      mval[0] = tv[i].sdo;
      wait_done(0, $sformatf("v%0d_wait", i));
      exp_rd[tv[i].eo] = tv[i].erd;
      if (tv[i].eo) e1++; else e0++;
      chk($sformatf("v%0d_owner", i), a_own, tv[i].eo);
      chk($sformatf("v%0d_datai", i), a_di, tv[i].edi);
      chk($sformatf("v%0d_rd0", i), a_rd0, exp_rd[0]);
      chk($sformatf("v%0d_rd1", i), a_rd1, exp_rd[1]);
      @(posedge SYSCLK); #1;
      chk($sformatf("v%0d_n0", i), n_a0, e0);
      chk($sformatf("v%0d_n1", i), n_a1, e1);
      chk($sformatf("v%0d_pulse", i), {a_d0, a_d1}, 0);
    end
    a_req0 = 0; a_req1 = 0;
    repeat (4) @(negedge SYSCLK);
    chk("tbl_err", a_err, 0);
    chk("tbl_idle", a_act, 0);
    chk("go_after_busy", go_viol, 0);

    // req0 dropped in XFER; req1 raised with done0
    a_req0 = 1; a_w0 = 8'h77; mval[0] = 8'hE1;
    wait_busy("rh_busy");
    a_req0 = 0;
    wait_done(0, "rh_wait0");
    chk("rh_done0", a_d0, 1);
    chk("rh_rd0", a_rd0, 8'hE1);
    a_req1 = 1; a_w1 = 8'h66; mval[0] = 8'hB2;
    begin
      int  gap = 0;
      bit  seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge SYSCLK);
        gap++;
        seen = a_go;
      end
      chk("rh_go_seen", seen, 1);
      chk("rh_gap_ge3", gap >= 3, 1);
    end
    chk("rh_owner1", a_own, 1);
    chk("rh_datai", a_di, 8'h66);
    wait_done(0, "rh_wait1");
    chk("rh_rd1", a_rd1, 8'hB2);
    a_req1 = 0;
    repeat (3) @(negedge SYSCLK);

    // reset during XFER
    a_req1 = 1; a_w1 = 8'h99; mval[0] = 8'h11;
    wait_busy("mr_busy");
    @(negedge SYSCLK);
    begin
      int nd;
      nd = n_a1;
      #2 resetb = 1'b0;
      #1;
      chk("mr_go", a_go, 0);
      chk("mr_srb", a_srb, 0);
      chk("mr_act", a_act, 0);
      repeat (3) @(negedge SYSCLK);
      a_req1 = 0;
      resetb = 1'b1;
      repeat (2) @(negedge SYSCLK);
      chk("mr_no_done", n_a1, nd);
      chk("mr_rd1", a_rd1, 0);
    end
    a_req1 = 1; a_w1 = 8'hC3; mval[0] = 8'h5E;
    wait_done(0, "mr_wait");
    chk("mr_done1", a_d1, 1);
    chk("mr_rd1_new", a_rd1, 8'h5E);
    chk("mr_datai", a_di, 8'hC3);
    a_req1 = 0;

    // fixed priority on the TIMEOUT_CYCLES=16 instance
    b_req0 = 1; b_req1 = 1; b_w0 = 8'h11; b_w1 = 8'h22;
    for (int i = 0; i < 3; i++) begin
      mval[1] = 8'h40 + 8'(i);
      wait_done(1, $sformatf("fp%0d_wait", i));
      chk($sformatf("fp%0d_owner", i), b_own, 0);
      chk($sformatf("fp%0d_datai", i), b_di, 8'h11);
      chk($sformatf("fp%0d_rd0", i), b_rd0, 8'h40 + 32'(i));
      @(posedge SYSCLK); #1;
    end
    b_req0 = 0; b_req1 = 0;
    repeat (4) @(negedge SYSCLK);
    chk("fp_n1", n_b1, 0);
    chk("fp_err", b_err, 0);

    // timeout: master never goes busy
    never[1] = 1'b1;
    begin
      int gon = 0, srl = 0, nd;
      nd = n_b0;
      b_req0 = 1; b_w0 = 8'h44;
      for (int k = 0; k < 40; k++) begin
        @(negedge SYSCLK);
        if (b_go) gon++;
        if (!b_srb) srl++;
        if (b_d0) b_req0 = 0;
      end
      chk("to_go_cycles", gon, 16);
      chk("to_srb_low", srl, 2);
      chk("to_done0", n_b0 - nd, 1);
      chk("to_rd0", b_rd0, 8'hFF);
      chk("to_err", b_err, 1);
      chk("to_idle", b_act, 0);
    end
    b_clr = 1;
    @(negedge SYSCLK);
    b_clr = 0;
    chk("to_clear", b_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_spi_arbiter.md
Name: mem_spi_arbiter

Overview:
- Sequences and shares the board-to-board SPI master (memory link) between two byte requesters.
  - Requester 0: the sensor-spoof fetch path.
  - Requester 1: the debug/trigger logger.
- Owns the master's go/busy handshake and captures the received byte for the granted requester.
- Recovers the master via its low-active reset when a transfer hangs.
- Sits between the requester logic and the spi_master instance, all on SYSCLK.

Parameters:
- TIMEOUT_CYCLES, 1024: SYSCLK cycles allowed in LAUNCH plus XFER before abort.
- FIXED_PRIO, 0: 0 = round-robin; 1 = requester 0 always wins ties.
- ERR_BYTE, 8'hFF: byte returned to the requester on timeout abort.

Ports:
- SYSCLK  in  1  system clock; all logic on rising edge.
- resetb  in  1  asynchronous, active-low reset.
- req0  in  1  requester 0 transfer request, level, held until done0.
- wdata0  in  8  byte to send for requester 0, stable while req0=1.
- rdata0  out  8  byte received for requester 0, valid from done0 onward.
- done0  out  1  one-cycle completion pulse for requester 0.
- req1  in  1  as req0, requester 1.
- wdata1  in  8  as wdata0, requester 1.
- rdata1  out  8  as rdata0, requester 1.
- done1  out  1  as done0, requester 1.
- spi_go  out  1  start strobe to the SPI master.
- spi_datai  out  8  byte to the SPI master.
- spi_busy  in  1  SPI master busy.
- spi_datao  in  8  byte received by the SPI master.
- spi_resetb  out  1  low-active reset to the SPI master.
- owner  out  1  index of the current or last granted requester.
- active  out  1  high in any state other than IDLE.
- err_timeout  out  1  sticky abort flag.
- err_clear  in  1  clears err_timeout; takes priority over a same-cycle set.

Behaviour:
- Reset values (resetb=0, async):
  - spi_go=0, spi_datai=0, rdata0=rdata1=0, done0=done1=0.
  - owner=0, active=0, err_timeout=0, spi_resetb=0 for the whole time resetb=0.
  - last_grant=1, so requester 0 wins the first tie; state=IDLE; timeout counter=0.
  - A reset in mid-transfer aborts it with no done pulse.
- After resetb rises, spi_resetb=1 from the first clock edge.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requests: round-robin grants the requester that is not last_grant. With FIXED_PRIO=1, requester 0 is granted.
  - On grant: owner set, spi_datai <= wdata[granted], counter cleared, move to LAUNCH.
- LAUNCH:
  - spi_go=1 every cycle in this state.
  - On the cycle spi_busy=1 is sampled: spi_go <= 0, move to XFER.
- XFER:
  - On the cycle spi_busy=0 is sampled: rdata[owner] <= spi_datao, move to DONE.
- DONE:
  - done[owner]=1 for exactly one cycle; last_grant <= owner; move to RECOVER.
- RECOVER:
  - One cycle with requests ignored, giving the requester a cycle to drop req; move to IDLE.
  - A req still high in IDLE after this is a new transfer.
- Minimum latency: req sampled in IDLE to done is 4 cycles plus the master's busy duration. Back-to-back grants are spaced at least 2 cycles after done.
- Timeout:
  - The counter increments every cycle in LAUNCH and XFER.
  - When counter == TIMEOUT_CYCLES-1: spi_go <= 0, spi_resetb <= 0 for 2 cycles, err_timeout <= 1, rdata[owner] <= ERR_BYTE, move to ABORT.
  - ABORT: after the 2-cycle reset pulse, perform the DONE behaviour (pulse done[owner], update last_grant), then RECOVER.
- Counter width: clog2(TIMEOUT_CYCLES)+1 bits; it never wraps because it is cleared on every grant.
- Request rules:
  - A req dropping before its done does not cancel a transfer in flight; done still pulses.
  - rdata of the non-owner is unchanged.
- wdata is sampled only at grant; later changes are ignored.
- spi_datai holds its value until the next grant.
- active=0 only in IDLE.

Test Plan:
- Single transfer: req0=1, wdata0=8'hFC; SPI model asserts busy 2 cycles after go, for 16 cycles, returns 8'hA5.
  - Required: spi_datai=8'hFC, spi_go deasserts the cycle after busy is seen, rdata0=8'hA5, one done0 pulse, done1 never pulses, err_timeout=0.
- Round-robin: req0 and req1 both held high for 4 transfers, wdata0=8'h11, wdata1=8'h22.
  - Required: owner sequence 0,1,0,1; spi_datai alternates 11,22,11,22.
  - With FIXED_PRIO=1, owner stays 0 while req0 stays high.
- Timeout: SPI model never asserts busy, TIMEOUT_CYCLES=16.
  - Required: spi_go high for 16 cycles, spi_resetb low for exactly 2 cycles, err_timeout=1, rdata0=8'hFF, done0 pulses once, state returns to IDLE.
  - Then err_clear=1 -> err_timeout=0.
- Reset mid-transfer: resetb low during XFER.
  - Required: immediately spi_go=0, spi_resetb=0, active=0, no done pulse.
  - After release, a new req1 transfer completes normally.
- Request handling: req0 dropped during XFER, and req1 asserted in the same cycle as done0.
  - Required: done0 still pulses; req1 is not granted until the IDLE cycle after RECOVER (done0 to spi_go for requester 1 is at least 3 cycles).
